// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit and the control unit that drives it.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b011,
        LHU = 3'b100
    } load_src_e;

    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10
    } store_src_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitR,
        StDone
    } lsu_state_e;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; undefined codes behave as words.
    function automatic logic is_misaligned(input logic       we,
                                           input logic [2:0] load_src,
                                           input logic [1:0] store_src,
                                           input logic [1:0] offset);
        logic mis;
        if (we) begin
            case (store_src)
                SB:      mis = 1'b0;
                SH:      mis = offset[0];
                default: mis = |offset;
            endcase
        end else begin
            case (load_src)
                LB, LBU: mis = 1'b0;
                LH, LHU: mis = offset[0];
                default: mis = |offset;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the LSU (master) and data memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  load_src_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then extension; undefined codes return the full word.
    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        result_o = word_i;
        case (load_src_i)
            LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
            LH:      result_o = {{16{half_sel[15]}}, half_sel};
            LBU:     result_o = {24'h000000, byte_sel};
            LHU:     result_o = {16'h0000, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory front end: aligns requests, builds byte enables, extends loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [2:0]               load_src,
    input  logic [1:0]               store_src,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     stall,
    output logic                     done,
    output logic [31:0]              rdata,
    output logic                     err,
    load_store_unit_if.master        mem
);

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  load_src_q, load_src_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] ext_word;

    lsu_load_extend u_load_extend (
        .word_i     (mem.mem_rdata),
        .offset_i   (off_q),
        .load_src_i (load_src_q),
        .result_o   (ext_word)
    );

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = wdata;
        if (req_we) begin
            case (store_src)
                SB: begin
                    req_be    = 4'b0001 << addr[1:0];
                    req_wdata = {4{wdata[7:0]}};
                end
                SH: begin
                    req_be    = 4'b0011 << {addr[1], 1'b0};
                    req_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = wdata;
                end
            endcase
        end
    end

    // Next-state logic; completion takes priority over the timeout in the same cycle.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        load_src_d  = load_src_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = '0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (is_misaligned(req_we, load_src, store_src, addr[1:0])) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d     = StReq;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata;
                        load_src_d  = load_src;
                        off_d       = addr[1:0];
                    end
                end
            end
            StReq: begin
                if (mem.mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = StDone;
                        err_d   = 1'b0;
                        rdata_d = '0;
                    end else if (mem.mem_rvalid) begin
                        state_d = StDone;
                        err_d   = 1'b0;
                        rdata_d = ext_word;
                    end else begin
                        // Counter keeps running across the REQ->WAIT_R hop.
                        state_d = StWaitR;
                        cnt_d   = cnt_q + TO_W'(1);
                    end
                end else if (cnt_q >= ToLast) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StWaitR: begin
                if (mem.mem_rvalid) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                    rdata_d = ext_word;
                end else if (cnt_q >= ToLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered memory-side outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            load_src_q  <= '0;
            off_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            load_src_q  <= load_src_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign stall = req_valid && (state_q != StDone);
    assign done  = (state_q == StDone);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses.
module tb_load_store_unit;

    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  load_src;
    logic [1:0]  store_src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    load_store_unit_if mif ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .load_src  (load_src),
        .store_src (store_src),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Results of the last run_access call.
    bit          r_done, r_saw_req, r_stall_ok, r_drop_ok, r_pulse_ok;
    logic        r_stall_done, r_req_at_done, r_err, r_we;
    int          r_cyc;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_be;

    // ---------------- reference model (access-size arithmetic) ----------------
    function automatic int acc_size(bit we, logic [2:0] ls, logic [1:0] ss);
        if (we) return (ss == 2'd0) ? 1 : (ss == 2'd1) ? 2 : 4;
        return (ls == 3'd0 || ls == 3'd3) ? 1 : (ls == 3'd1 || ls == 3'd4) ? 2 : 4;
    endfunction

    function automatic bit model_mis(bit we, logic [2:0] ls, logic [1:0] ss, logic [31:0] a);
        return (a % acc_size(we, ls, ss)) != 0;
    endfunction

    function automatic logic [3:0] model_be(bit we, logic [2:0] ls, logic [1:0] ss,
                                            logic [31:0] a);
        int sz = acc_size(we, ls, ss);
        if (!we) return 4'hF;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] ss, logic [31:0] d);
        if (ss == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (ss == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] ls, logic [31:0] a, logic [31:0] w);
        int          sz   = acc_size(1'b0, ls, 2'd0);
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        logic [31:0] v    = (w >> (8 * (a % 4))) & mask;
        bit          sgn  = (ls == 3'd0) || (ls == 3'd1);
        if (sgn && sz < 4 && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        return v;
    endfunction

    // Drives one core access and plays the memory side; stops at done or after bound cycles.
    task automatic run_access(input bit we, input logic [2:0] ls, input logic [1:0] ss,
                              input logic [31:0] a, input logic [31:0] d, input int rdy_dly,
                              input int rv_dly, input logic [31:0] word, input int bound);
        int waitc, since;
        bit acc, acc_now, given;
        waitc = 0; since = 0; acc = 0; given = 0;
        r_done = 0; r_cyc = 0; r_saw_req = 0; r_stall_ok = 1; r_drop_ok = 1; r_pulse_ok = 0;
        r_rdata = 'x; r_err = 1'bx; r_stall_done = 1'bx; r_req_at_done = 1'bx;
        r_addr = 'x; r_be = 'x; r_wdata = 'x; r_we = 1'bx;
        req_valid = 1'b1; req_we = we; load_src = ls; store_src = ss; addr = a; wdata = d;
        for (int c = 0; c < bound && !r_done; c++) begin
            acc_now = 0;
            mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = $urandom;
            if (acc && mif.mem_req === 1'b1) r_drop_ok = 0;
            if (!acc && mif.mem_req === 1'b1) begin
                if (!r_saw_req) begin
                    r_saw_req = 1; r_addr = mif.mem_addr; r_be = mif.mem_be;
                    r_wdata = mif.mem_wdata; r_we = mif.mem_we;
                end
                if (waitc >= rdy_dly) begin
                    mif.mem_ready = 1'b1; acc_now = 1;
                    if (!we && rv_dly == 0) begin
                        mif.mem_rvalid = 1'b1; mif.mem_rdata = word; given = 1;
                    end
                end else begin
                    waitc++;
                end
            end else if (acc && !we && !given) begin
                since++;
                if (since >= rv_dly) begin
                    mif.mem_rvalid = 1'b1; mif.mem_rdata = word; given = 1;
                end
            end
            #1;
            if (stall !== 1'b1) r_stall_ok = 0;
            @(posedge clk); #1;
            r_cyc++;
            if (acc_now) acc = 1;
            if (done === 1'b1) begin
                r_done = 1; r_rdata = rdata; r_err = err;
                r_stall_done = stall; r_req_at_done = mif.mem_req;
            end
        end
        req_valid = 1'b0; mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0;
        @(posedge clk); #1;
        r_pulse_ok = r_done && (done === 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; load_src = 3'd0; store_src = 2'd0;
        addr = '0; wdata = '0;
        mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata} !== 70'd0) begin
            bad++;
            $display("FAIL reset_mem: got req=%b we=%b be=%b addr=%h wdata=%h want all 0",
                     mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata);
        end
        total++;
        if ({rdata, err, done, stall} !== 35'd0) begin
            bad++;
            $display("FAIL reset_core: got rdata=%h err=%b done=%b stall=%b want all 0",
                     rdata, err, done, stall);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || mif.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got done=%b req=%b want 0 0", done, mif.mem_req);
        end
    endtask

    task automatic test_store_sw();
        run_access(1'b1, 3'd0, 2'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, 20);
        total++;
        if (!r_done || r_cyc != 2 || r_err !== 1'b0) begin
            bad++;
            $display("FAIL sw_done: got done=%0b cyc=%0d err=%b want 1 2 0", r_done, r_cyc, r_err);
        end
        total++;
        if ({r_we, r_addr, r_be, r_wdata} !== {1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL sw_bus: got we=%b addr=%h be=%b wdata=%h want 1 00000100 1111 deadbeef",
                     r_we, r_addr, r_be, r_wdata);
        end
        total++;
        if (!r_stall_ok || r_stall_done !== 1'b0 || !r_pulse_ok || !r_drop_ok) begin
            bad++;
            $display("FAIL sw_ctrl: got stall_ok=%0b stall_at_done=%b pulse=%0b drop=%0b want 1 0 1 1",
                     r_stall_ok, r_stall_done, r_pulse_ok, r_drop_ok);
        end
    endtask

    task automatic test_store_sb();
        run_access(1'b1, 3'd0, 2'd0, 32'h103, 32'h0000_00A5, 1, 0, 32'h0, 20);
        total++;
        if ({r_addr, r_be, r_wdata} !== {32'h100, 4'b1000, 32'hA5A5_A5A5} || r_cyc != 3) begin
            bad++;
            $display("FAIL sb_bus: got addr=%h be=%b wdata=%h cyc=%0d want 00000100 1000 a5a5a5a5 3",
                     r_addr, r_be, r_wdata, r_cyc);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ls_t  [4] = '{3'd0, 3'd3, 3'd1, 3'd4};
        logic [31:0] a_t   [4] = '{32'h2, 32'h2, 32'h0, 32'h2};
        logic [31:0] exp_t [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_7F01, 32'h0000_80F0};
        for (int i = 0; i < 4; i++) begin
            run_access(1'b0, ls_t[i], 2'd0, a_t[i], 32'h0, 0, 3, 32'h80F0_7F01, 40);
            total++;
            if (!r_done || r_rdata !== exp_t[i] || r_err !== 1'b0 || r_cyc != 5 || !r_stall_ok) begin
                bad++;
                $display("FAIL load_%0d: got done=%0b rdata=%h err=%b cyc=%0d stall_ok=%0b want 1 %h 0 5 1",
                         i, r_done, r_rdata, r_err, r_cyc, r_stall_ok, exp_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        req_valid = 1'b1; req_we = 1'b0; load_src = 3'd2; store_src = 2'd0;
        addr = 32'h40; wdata = '0; mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (mif.mem_req === 1'b1) seen = 1;
        end
        mif.mem_ready = 1'b1;
        @(posedge clk); #1;
        mif.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mif.mem_rvalid = 1'b0;
        total++;
        if (!seen || done !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_core: got seen=%0b done=%b rdata=%h err=%b want 1 0 0 0",
                     seen, done, rdata, err);
        end
        total++;
        if ({mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata} !== 70'd0) begin
            bad++;
            $display("FAIL rst_mid_mem: got req=%b be=%b addr=%h want 0 0 0",
                     mif.mem_req, mif.mem_be, mif.mem_addr);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_late: got done=%b want 0", done);
        end
        run_access(1'b0, 3'd1, 2'd0, 32'h46, 32'h0, 0, 1, 32'h9ABC_1234, 40);
        total++;
        if (r_rdata !== 32'hFFFF_9ABC || r_err !== 1'b0 || r_cyc != 3) begin
            bad++;
            $display("FAIL rst_mid_next: got rdata=%h err=%b cyc=%0d want ffff9abc 0 3",
                     r_rdata, r_err, r_cyc);
        end
    endtask

    task automatic test_misaligned();
        bit          we_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  ls_t [4] = '{3'd2, 3'd0, 3'd4, 3'd0};
        logic [1:0]  ss_t [4] = '{2'd0, 2'd1, 2'd0, 2'd2};
        logic [31:0] a_t  [4] = '{32'h102, 32'h101, 32'h3, 32'h1};
        for (int i = 0; i < 4; i++) begin
            run_access(we_t[i], ls_t[i], ss_t[i], a_t[i], 32'h55, 0, 0, 32'h0, 10);
            total++;
            if (!r_done || r_cyc != 1 || r_err !== 1'b1 || r_saw_req) begin
                bad++;
                $display("FAIL misaligned_%0d: got done=%0b cyc=%0d err=%b req_seen=%0b want 1 1 1 0",
                         i, r_done, r_cyc, r_err, r_saw_req);
            end
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'd2, 2'd0, 32'h200, 32'h0, 1000000, 0, 32'h0, TO + 20);
        total++;
        if (!r_done || r_cyc < TO || r_cyc > TO + 2) begin
            bad++;
            $display("FAIL timeout_lat: got done=%0b cyc=%0d want done within %0d..%0d",
                     r_done, r_cyc, TO, TO + 2);
        end
        total++;
        if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_req_at_done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_out: got err=%b rdata=%h req=%b want 1 0 0",
                     r_err, r_rdata, r_req_at_done);
        end
    endtask

    task automatic test_random();
        bit          we;
        logic [2:0]  ls;
        logic [1:0]  ss;
        logic [31:0] a, d, w, exp_rd;
        int          rdy, rv, exp_cyc;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1)); ls = 3'($urandom_range(0, 7));
            ss = 2'($urandom_range(0, 3)); a = $urandom; d = $urandom; w = $urandom;
            rdy = $urandom_range(0, 4); rv = $urandom_range(0, 4);
            run_access(we, ls, ss, a, d, rdy, rv, w, 40);
            if (model_mis(we, ls, ss, a)) begin
                total++;
                if (!r_done || r_cyc != 1 || r_err !== 1'b1 || r_saw_req) begin
                    bad++;
                    $display("FAIL rand_mis_%0d: got done=%0b cyc=%0d err=%b req_seen=%0b want 1 1 1 0",
                             i, r_done, r_cyc, r_err, r_saw_req);
                end
            end else begin
                exp_cyc = 2 + rdy + (we ? 0 : rv);
                total++;
                if (!r_done || r_cyc != exp_cyc || r_err !== 1'b0 || !r_stall_ok || !r_drop_ok) begin
                    bad++;
                    $display("FAIL rand_ctl_%0d: got done=%0b cyc=%0d err=%b stall_ok=%0b drop=%0b want 1 %0d 0 1 1",
                             i, r_done, r_cyc, r_err, r_stall_ok, r_drop_ok, exp_cyc);
                end
                total++;
                if ({r_we, r_addr, r_be} !== {we, a & 32'hFFFF_FFFC, model_be(we, ls, ss, a)}) begin
                    bad++;
                    $display("FAIL rand_bus_%0d: got we=%b addr=%h be=%b want %b %h %b", i, r_we,
                             r_addr, r_be, we, a & 32'hFFFF_FFFC, model_be(we, ls, ss, a));
                end
                if (we) begin
                    total++;
                    if (r_wdata !== model_wdata(ss, d)) begin
                        bad++;
                        $display("FAIL rand_wdata_%0d: got %h want %h", i, r_wdata,
                                 model_wdata(ss, d));
                    end
                end else begin
                    exp_rd = model_load(ls, a, w);
                    total++;
                    if (r_rdata !== exp_rd) begin
                        bad++;
                        $display("FAIL rand_rdata_%0d: got %h want %h (ls=%0d addr=%h word=%h)",
                                 i, r_rdata, exp_rd, ls, a, w);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_sw();
        test_store_sb();
        test_loads();
        test_reset_mid();
        test_misaligned();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
